inst_fetch_ctrl: RTL and testbench

- Program-counter and fetch sequencer for the combinational instruction ROM (A-bit address, W-bit instruction).
- Owns the PC, drives the ROM address and qualifies the fetched word for the decoder.
- Applies branch redirects supplied by decode/execute and stops the program on the halt encoding (all ones).
- Sits between the top-level run control (start/abort) and the ROM/decoder.

---
 rtl/inst_fetch_ctrl_pkg.sv | 17 +
 rtl/inst_fetch_ctrl_sat_counter.sv | 29 ++
 rtl/inst_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_inst_fetch_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller and its ROM.
// Default address/instruction widths match the instruction ROM.
package inst_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam int A_DEF  = 8;
    localparam int W_DEF  = 9;
    localparam int CW_DEF = 16;

    localparam logic [W_DEF-1:0] HALT_OP = {W_DEF{1'b1}};

endpackage

// File: rtl/inst_fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module inst_fetch_ctrl_sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_count
);

    logic [CW-1:0] r_count;

    // Count register: clear, then increment unless already at the top value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CW{1'b0}};
        end else if (i_clr) begin
            r_count <= {CW{1'b0}};
        end else if (i_en && (r_count != {CW{1'b1}})) begin
            r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Program counter and fetch sequencer for a combinational instruction ROM:
// run control, branch redirect, halt-on-all-ones and a run-cycle counter.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int A  = A_DEF,
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [A-1:0]  StartAddr,
    input  logic          Abort,
    input  logic          Stall,
    input  logic          BranchTaken,
    input  logic          BranchAbs,
    input  logic [A-1:0]  Target,
    input  logic [W-1:0]  InstIn,
    output logic [A-1:0]  InstAddress,
    output logic          InstValid,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    localparam logic [W-1:0] L_HALT_OP = {W{1'b1}};

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [A-1:0] r_pc;
    logic [A-1:0] w_pc_nxt;
    logic         r_running;
    logic         r_done;
    logic         w_cnt_clr;
    logic         w_cnt_en;

    // Next-state and next-PC selection; Abort outranks everything, Stall masks halt and branch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = StartAddr;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (Abort) begin
                    w_state_nxt = ST_IDLE;
                    w_pc_nxt    = {A{1'b0}};
                end else if (Stall) begin
                    w_pc_nxt    = r_pc;
                end else if (InstIn == L_HALT_OP) begin
                    w_state_nxt = ST_HALT;
                end else if (BranchTaken) begin
                    w_pc_nxt = BranchAbs ? Target : (r_pc + Target);
                end else begin
                    w_pc_nxt = r_pc + {{(A-1){1'b0}}, 1'b1};
                end
            end
            ST_HALT: begin
                if (Abort) begin
                    w_state_nxt = ST_IDLE;
                    w_pc_nxt    = {A{1'b0}};
                end else if (Start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = StartAddr;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = {A{1'b0}};
            end
        endcase
    end

    // State, PC and status flags; flags are registered from the next state so they track r_state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= {A{1'b0}};
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_HALT);
        end
    end

    assign w_cnt_en = (r_state == ST_RUN);

    inst_fetch_ctrl_sat_counter #(
        .CW (CW)
    ) u_cycle_cnt (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (CycleCount)
    );

    assign InstAddress = r_pc;
    assign InstValid   = r_running;
    assign Running     = r_running;
    assign Done        = r_done;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios then random stimulus,
// compared each cycle against a behavioural model with a ROM array.
module tb_inst_fetch_ctrl;

    localparam int AT  = 8;
    localparam int WT  = 9;
    localparam int CWT = 4;
    localparam int CNT_MAX = (1 << CWT) - 1;

    logic            Clk;
    logic            Reset_n;
    logic            Start;
    logic [AT-1:0]   StartAddr;
    logic            Abort;
    logic            Stall;
    logic            BranchTaken;
    logic            BranchAbs;
    logic [AT-1:0]   Target;
    logic [WT-1:0]   InstIn;
    logic [AT-1:0]   InstAddress;
    logic            InstValid;
    logic            Running;
    logic            Done;
    logic [CWT-1:0]  CycleCount;

    logic [WT-1:0] rom [256];

    int n_checks = 0;
    int n_errors = 0;

    // model: mode 0 = idle, 1 = run, 2 = halt
    int m_mode;
    int m_pc;
    int m_cnt;

    inst_fetch_ctrl #(.A(AT), .W(WT), .CW(CWT)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .StartAddr   (StartAddr),
        .Abort       (Abort),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .BranchAbs   (BranchAbs),
        .Target      (Target),
        .InstIn      (InstIn),
        .InstAddress (InstAddress),
        .InstValid   (InstValid),
        .Running     (Running),
        .Done        (Done),
        .CycleCount  (CycleCount)
    );

    assign InstIn = rom[InstAddress];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("addr",    32'(InstAddress), 32'(m_pc));
        check("valid",   32'(InstValid),   32'(m_mode == 1));
        check("running", 32'(Running),     32'(m_mode == 1));
        check("done",    32'(Done),        32'(m_mode == 2));
        check("cycles",  32'(CycleCount),  32'(m_cnt));
    endtask

    task automatic model_step(input logic st, input int sa, input logic ab, input logic stl,
                              input logic bt, input logic babs, input int tgt);
        if (m_mode == 0) begin
            if (st) begin m_mode = 1; m_pc = sa; m_cnt = 0; end
        end else if (m_mode == 1) begin
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (ab) begin
                m_mode = 0; m_pc = 0;
            end else if (stl) begin
                m_pc = m_pc;
            end else if (rom[m_pc] == 9'h1FF) begin
                m_mode = 2;
            end else if (bt) begin
                m_pc = babs ? tgt : (m_pc + tgt) % 256;
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end else begin
            if (ab) begin
                m_mode = 0; m_pc = 0;
            end else if (st) begin
                m_mode = 1; m_pc = sa; m_cnt = 0;
            end
        end
    endtask

    task automatic cyc(input logic st, input logic [7:0] sa, input logic ab, input logic stl,
                       input logic bt, input logic babs, input logic [7:0] tgt);
        Start = st; StartAddr = sa; Abort = ab; Stall = stl;
        BranchTaken = bt; BranchAbs = babs; Target = tgt;
        model_step(st, int'(sa), ab, stl, bt, babs, int'(tgt));
        @(posedge Clk);
        #1;
        check_all();
        Start = 1'b0; Abort = 1'b0; Stall = 1'b0; BranchTaken = 1'b0;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 9'($urandom_range(0, 510));
        rom[5] = 9'h001; rom[6] = 9'h002; rom[7] = 9'h1FF;
        Reset_n = 1'b0; Start = 1'b0; StartAddr = 8'h00; Abort = 1'b0; Stall = 1'b0;
        BranchTaken = 1'b0; BranchAbs = 1'b0; Target = 8'h00;
        m_mode = 0; m_pc = 0; m_cnt = 0;
        #12;
        check_all();
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        check_all();

        // linear run into halt
        cyc(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_cyc();
        idle_cyc();
        idle_cyc();
        check("lin_done", 32'(Done), 32'd1);
        check("lin_addr", 32'(InstAddress), 32'd7);
        check("lin_cnt",  32'(CycleCount), 32'd3);
        idle_cyc();

        // absolute then relative branch; Start in RUN ignored
        cyc(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40);
        check("br_abs", 32'(InstAddress), 32'h40);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFE);
        check("br_rel", 32'(InstAddress), 32'h3E);
        cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("start_in_run", 32'(InstAddress), 32'h3F);

        // wrap from the top of the address space
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_cyc();
        idle_cyc();
        check("wrap", 32'(InstAddress), 32'h00);

        // stall masks halt for three cycles
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("stall_run", 32'(Running), 32'd1);
        check("stall_cnt", 32'(CycleCount), 32'd3);
        idle_cyc();
        check("stall_halt", 32'(Done), 32'd1);

        // Abort+Start in HALT, then Start alone from HALT
        cyc(1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("halt_abort_pc", 32'(InstAddress), 32'd0);
        cyc(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_cyc();
        cyc(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("restart_pc",  32'(InstAddress), 32'd3);
        check("restart_cnt", 32'(CycleCount), 32'd0);

        // relative offset 0 self-loop long enough to saturate the counter
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 20; k++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("selfloop_pc", 32'(InstAddress), 32'h80);
        check("sat_cnt", 32'(CycleCount), 32'(CNT_MAX));

        // asynchronous reset between edges at PC 0x22
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_cyc();
        idle_cyc();
        check("pre_reset_pc", 32'(InstAddress), 32'h22);
        #2;
        Reset_n = 1'b0;
        m_mode = 0; m_pc = 0; m_cnt = 0;
        #1;
        check_all();
        check("async_running", 32'(Running), 32'd0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        idle_cyc();
        idle_cyc();

        // random stimulus with occasional halt words
        for (int i = 0; i < 256; i++)
            rom[i] = ($urandom_range(0, 19) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
        for (int n = 0; n < 600; n++) begin
            cyc(1'($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom_range(0, 31) == 0),
                1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0),
                1'($urandom), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
